// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encodings and default latencies for pipeline_ctrl and its HI/LO sequencer.
// The optional exception-cancel input is enabled with the MD_CANCEL_EN macro.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_MUL_LAT    = 4;
  localparam int unsigned DEF_DIV_LAT    = 32;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_md_seq.sv
// md_seq: IDLE/BUSY/DONE sequencer and down-counter for the multiply/divide (HI/LO) unit.
// With MD_CANCEL_EN defined, cancel_i aborts an operation and drops any start in the same cycle.
module pipeline_ctrl_md_seq
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned CNT_W   = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_div_i,
`ifdef MD_CANCEL_EN
  input  logic             cancel_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cancel;

`ifdef MD_CANCEL_EN
  assign cancel = cancel_i;
`else
  assign cancel = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_o  = 1'b0;
    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        // A cancelled op must not write HI/LO, so the DONE pulse is masked too.
        done_o  = (state_q == MD_DONE) & ~cancel;
        count_d = '0;
        if (start_i & ~cancel) begin
          state_d = MD_BUSY;
          count_d = is_div_i ? DivLoad : MulLoad;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cancel) begin
          state_d = MD_IDLE;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = MD_DONE;
        end else begin
          count_d = count_q - CntOne;
        end
      end
      default: begin
        state_d = MD_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign busy_o  = (state_q == MD_BUSY);
  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Load-use and HI/LO structural hazard controller for the 5-stage MIPS pipeline.
// Define MD_CANCEL_EN to add the mdCancel exception-flush input.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned MUL_LAT    = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT    = DEF_DIV_LAT,
  parameter int unsigned CNT_W      = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic                  useRsD,
  input  logic                  useRtD,
  input  logic [REG_ADDR_W-1:0] writeRegE,
  input  logic                  regWriteE,
  input  logic                  memToRegE,
  input  logic                  mdStartD,
  input  logic                  mdIsDivD,
  input  logic                  mdReadD,
  input  logic                  branchTakenD,
`ifdef MD_CANCEL_EN
  input  logic                  mdCancel,
`endif
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  mdBusy,
  output logic                  mdDone,
  output logic [CNT_W-1:0]      mdCount
);

  logic lu_haz, md_haz, stall, md_start;

  always_comb begin
    lu_haz = memToRegE & regWriteE & (writeRegE != '0) &
             ((useRsD & (rsD == writeRegE)) | (useRtD & (rtD == writeRegE)));
    md_haz = mdBusy & (mdStartD | mdReadD);
    // Gate with reset so every output reads 0 while reset is held.
    stall  = rst & (lu_haz | md_haz);
    stallF = stall;
    stallD = stall;
    flushE = stall;
    flushD = rst & branchTakenD & ~stall;
    // A start seen while BUSY is already stalled, so only IDLE/DONE can accept.
    md_start = mdStartD & ~stall;
  end

  pipeline_ctrl_md_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_seq (
    .clk_i    (clk),
    .rst_ni   (rst),
    .start_i  (md_start),
    .is_div_i (mdIsDivD),
`ifdef MD_CANCEL_EN
    .cancel_i (mdCancel),
`endif
    .busy_o   (mdBusy),
    .done_o   (mdDone),
    .count_o  (mdCount)
  );

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequential hazard and multi-cycle-operation controller for the 5-stage MIPS pipeline. It sits beside the decode-stage control unit and consumes its decoded register-use, load and branch signals. It produces per-stage stall and flush controls, and sequences a parametrised-latency multiply/divide (HI/LO) unit. This replaces ad-hoc combinational interlocks with one registered, latency-configurable block.

## Interface
Parameters:
- REG_ADDR_W, default 5: register address width.
- MUL_LAT, default 4: multiply latency in cycles; must be ≥1.
- DIV_LAT, default 32: divide latency in cycles; must be ≥1.
- CNT_W, default $clog2(max(MUL_LAT,DIV_LAT)+1): busy counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rsD, rtD  in  REG_ADDR_W each  source register addresses of the decode-stage instruction.
- useRsD, useRtD  in  1 each  decode-stage instruction reads rs / rt.
- writeRegE  in  REG_ADDR_W  destination register of the execute-stage instruction.
- regWriteE  in  1  execute-stage instruction writes the register file.
- memToRegE  in  1  execute-stage instruction is a load.
- mdStartD  in  1  decode-stage instruction is mult/multu/div/divu.
- mdIsDivD  in  1  selects DIV_LAT (1) or MUL_LAT (0); sampled only when a start is accepted.
- mdReadD  in  1  decode-stage instruction is mfhi/mflo.
- branchTakenD  in  1  decode-stage branch or jump is resolved taken.
- mdCancel  in  1  exception flush; present only with MD_CANCEL_EN defined.
- stallF, stallD  out  1 each  hold PC and the IF/ID register.
- flushD  out  1  clear the IF/ID register.
- flushE  out  1  insert a bubble into ID/EX.
- mdBusy  out  1  HI/LO unit operation in flight.
- mdDone  out  1  one-cycle pulse: the HI/LO result writes this cycle.
- mdCount  out  CNT_W  remaining busy cycles, for debug and test.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset puts it in IDLE with mdCount=0.
- The load-use hazard luHaz is defined as: memToRegE & regWriteE & writeRegE≠0 & ((useRsD & rsD==writeRegE) | (useRtD & rtD==writeRegE)).
- The structural hazard mdHaz is defined as: state==BUSY & (mdStartD | mdReadD).
- The hazard signal stall = luHaz | mdHaz.
  - While stall is high, stallF = stallD = flushE = 1.
- Taken branch: flushD = branchTakenD & ~stall.
  - A stall overrides a branch flush; the branch re-resolves on the next cycle.
- Start acceptance: when mdStartD & ~stall and the state is IDLE or DONE:
  - the FSM goes to BUSY;
  - mdCount loads (mdIsDivD ? DIV_LAT : MUL_LAT) − 1.
- BUSY state:
  - if mdCount==0, the next state is DONE;
  - otherwise mdCount decrements.
- DONE state: mdDone=1 for exactly one cycle. The next state is IDLE, or BUSY if a new start is accepted in this same cycle.
- mfhi/mflo issued in DONE does not stall. HI/LO forwarding handles it outside this block.
- mdBusy = (state==BUSY).
- mdCount is 0 in IDLE and in DONE.
- Reset mid-operation aborts immediately: state goes to IDLE, no mdDone pulse, and all outputs go low.

## Timing
- The hazard outputs (stall*, flush*) are combinational from the current inputs and state, with no added latency.
- Start accepted in cycle 0:
  - BUSY is asserted in cycles 1..LAT;
  - mdCount counts LAT−1 down to 0;
  - mdDone is high in cycle LAT+1.
- Reset values: every output is 0.
- Back-to-back operations: a start held in DONE is accepted. mdDone and the new operation's first BUSY cycle are adjacent, with no idle gap.

## Configuration
- The macro is MD_CANCEL_EN.
- Defined:
  - the mdCancel port exists;
  - mdCancel high in BUSY or DONE forces IDLE on the next edge and suppresses mdDone;
  - mdCancel takes priority over a simultaneous start, which is dropped.
- Undefined: the port is absent, and operations always run to completion.

## Structure
- The shared defines header holds:
  - the FSM state encodings MD_IDLE, MD_BUSY and MD_DONE;
  - the default latency constants.
- Sub-module md_seq contains the FSM and counter. It is parametrised by MUL_LAT, DIV_LAT and CNT_W.
- The top level holds the hazard equations and instantiates md_seq.

## Test plan
- Load-use: memToRegE=1, regWriteE=1, writeRegE=8, rsD=8, useRsD=1 -> stallF=stallD=flushE=1, flushD=0.
- Same case with writeRegE=0 -> no stall.
- Multiply: MUL_LAT=4, mdStartD=1, mdIsDivD=0 in cycle 0 -> mdBusy high in cycles 1–4, mdCount 3,2,1,0, mdDone high in cycle 5 only.
- Structural: DIV_LAT=32, start a divide, then hold mdReadD=1 -> stall for 32 cycles, released in the DONE cycle.
- Branch vs stall: branchTakenD=1 with a load-use hazard -> flushD=0. Clear the hazard on the next cycle -> flushD=1.
- Back-to-back starts and reset abort:
  - with mdStartD held through DONE -> mdDone pulse immediately followed by mdCount=MUL_LAT−1;
  - with rst low in BUSY cycle 2 -> all outputs 0 and no mdDone.
- MD_CANCEL_EN build: mdCancel=1 in BUSY cycle 2 -> IDLE on the next edge and no mdDone.
